// File: rtl/gat_pkg.sv
// Shared types and helpers for the GAT BRAM load controller.
package gat_pkg;

  localparam int DEF_ADDR_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } load_state_t;

  // Byte addresses are handled at 32 bits; callers zero-extend and slice.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr, input int shift);
    return byte_addr >> shift;
  endfunction

  function automatic logic addr_misaligned(input logic [31:0] byte_addr, input int shift);
    logic [31:0] mask;
    mask = (32'd1 << shift) - 32'd1;
    return |(byte_addr & mask);
  endfunction

endpackage

// File: rtl/gat_load_ch.sv
// One load channel: input register stage, accept filter, write counter
// against a latched depth, and sticky error flags.
module gat_load_ch
  import gat_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 20,
  parameter int ADDR_SHIFT = DEF_ADDR_SHIFT,
  parameter int CNT_W      = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         restart_i,
  input  logic                         in_load_i,
  input  logic [CNT_W-1:0]             cfg_depth_i,
  input  logic [DATA_W-1:0]            s_din_i,
  input  logic                         s_ena_i,
  input  logic                         s_wea_i,
  input  logic [ADDR_W-1:0]            s_addra_i,
  output logic [DATA_W-1:0]            m_din_o,
  output logic                         m_ena_o,
  output logic                         m_wea_o,
  output logic [ADDR_W-ADDR_SHIFT-1:0] m_addra_o,
  output logic                         ch_done_o,
  output logic                         err_misalign_o,
  output logic                         err_range_o,
  output logic                         err_locked_o
);

  logic [31:0]                  word;
  logic                         misalign, full, oob, wr_live, rd, accept;

  logic [CNT_W-1:0]             cnt_q, cnt_d, depth_q, depth_d;
  logic                         armed_q, armed_d;
  logic                         err_mis_q, err_mis_d;
  logic                         err_rng_q, err_rng_d;
  logic                         err_lck_q, err_lck_d;
  logic [DATA_W-1:0]            m_din_q;
  logic [ADDR_W-ADDR_SHIFT-1:0] m_addra_q;
  logic                         m_ena_q, m_wea_q;

  assign word     = word_addr(32'(s_addra_i), ADDR_SHIFT);
  assign misalign = addr_misaligned(32'(s_addra_i), ADDR_SHIFT);
  assign full     = (cnt_q == depth_q);
  assign oob      = (word >= 32'(depth_q));
  // A restart in the same cycle swallows the write silently.
  assign wr_live  = s_ena_i & s_wea_i & ~restart_i;
  assign rd       = s_ena_i & ~s_wea_i;
  assign accept   = wr_live & in_load_i & ~misalign & ~oob & ~full;

  always_comb begin
    cnt_d     = cnt_q;
    depth_d   = depth_q;
    armed_d   = armed_q;
    err_mis_d = err_mis_q;
    err_rng_d = err_rng_q;
    err_lck_d = err_lck_q;
    if (restart_i) begin
      cnt_d     = '0;
      depth_d   = cfg_depth_i;
      armed_d   = 1'b1;
      err_mis_d = 1'b0;
      err_rng_d = 1'b0;
      err_lck_d = 1'b0;
    end else begin
      if (accept) cnt_d = cnt_q + CNT_W'(1);
      if (wr_live && !in_load_i) err_lck_d = 1'b1;
      if (wr_live && in_load_i && misalign) err_mis_d = 1'b1;
      // A full channel rejects further writes as out of range.
      if (wr_live && in_load_i && (oob || full)) err_rng_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      depth_q   <= '0;
      armed_q   <= 1'b0;
      err_mis_q <= 1'b0;
      err_rng_q <= 1'b0;
      err_lck_q <= 1'b0;
      m_din_q   <= '0;
      m_addra_q <= '0;
      m_ena_q   <= 1'b0;
      m_wea_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      depth_q   <= depth_d;
      armed_q   <= armed_d;
      err_mis_q <= err_mis_d;
      err_rng_q <= err_rng_d;
      err_lck_q <= err_lck_d;
      m_din_q   <= s_din_i;
      m_addra_q <= word[ADDR_W-ADDR_SHIFT-1:0];
      m_ena_q   <= accept | rd;
      m_wea_q   <= accept;
    end
  end

  // armed_q keeps the reset-time 0 == 0 compare from reading as done.
  assign ch_done_o      = armed_q & full;
  assign m_din_o        = m_din_q;
  assign m_addra_o      = m_addra_q;
  assign m_ena_o        = m_ena_q;
  assign m_wea_o        = m_wea_q;
  assign err_misalign_o = err_mis_q;
  assign err_range_o    = err_rng_q;
  assign err_locked_o   = err_lck_q;

endmodule

// File: rtl/gat_bram_load_ctrl.sv
// N-channel BRAM load controller: per-channel write filtering and counting,
// then a start pulse to the GAT core and tracking until it reports ready.
module gat_bram_load_ctrl
  import gat_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 20,
  parameter int ADDR_SHIFT = DEF_ADDR_SHIFT,
  parameter int CNT_W      = 18
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load_start,
  input  logic [NUM_CH*CNT_W-1:0]             cfg_depth,
  input  logic [NUM_CH*DATA_W-1:0]            s_din,
  input  logic [NUM_CH-1:0]                   s_ena,
  input  logic [NUM_CH-1:0]                   s_wea,
  input  logic [NUM_CH*ADDR_W-1:0]            s_addra,
  output logic [NUM_CH*DATA_W-1:0]            m_din,
  output logic [NUM_CH-1:0]                   m_ena,
  output logic [NUM_CH-1:0]                   m_wea,
  output logic [NUM_CH*(ADDR_W-ADDR_SHIFT)-1:0] m_addra,
  output logic [NUM_CH-1:0]                   ch_done,
  output logic                                gat_start,
  input  logic                                gat_ready,
  output logic                                layer_done,
  output logic                                busy,
  output logic [NUM_CH-1:0]                   err_misalign,
  output logic [NUM_CH-1:0]                   err_range,
  output logic [NUM_CH-1:0]                   err_locked,
  output logic [1:0]                          dbg_state
);

  localparam int WA_W = ADDR_W - ADDR_SHIFT;

  load_state_t state_q, state_d;
  logic        ready_q;
  logic        layer_done_q, layer_done_d;
  logic        restart, in_load, all_done, ready_rise;

  // load_start is honoured only before the core has been started.
  assign restart    = load_start & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
  assign in_load    = (state_q == ST_LOAD);
  assign all_done   = &ch_done;
  assign ready_rise = gat_ready & ~ready_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    gat_load_ch #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .ADDR_SHIFT(ADDR_SHIFT),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .restart_i     (restart),
      .in_load_i     (in_load),
      .cfg_depth_i   (cfg_depth[k*CNT_W +: CNT_W]),
      .s_din_i       (s_din[k*DATA_W +: DATA_W]),
      .s_ena_i       (s_ena[k]),
      .s_wea_i       (s_wea[k]),
      .s_addra_i     (s_addra[k*ADDR_W +: ADDR_W]),
      .m_din_o       (m_din[k*DATA_W +: DATA_W]),
      .m_ena_o       (m_ena[k]),
      .m_wea_o       (m_wea[k]),
      .m_addra_o     (m_addra[k*WA_W +: WA_W]),
      .ch_done_o     (ch_done[k]),
      .err_misalign_o(err_misalign[k]),
      .err_range_o   (err_range[k]),
      .err_locked_o  (err_locked[k])
    );
  end

  always_comb begin
    state_d      = state_q;
    layer_done_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (load_start) state_d = ST_LOAD;
      ST_LOAD:  if (!load_start && all_done) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (ready_rise) begin
          state_d      = ST_IDLE;
          layer_done_d = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= gat_ready;
      layer_done_q <= layer_done_d;
    end
  end

  assign gat_start  = (state_q == ST_START);
  assign busy       = (state_q != ST_IDLE);
  assign layer_done = layer_done_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/gat_bram_load_ctrl.md
# gat_bram_load_ctrl

Multi-channel load controller between the AXI BRAM controllers and the GAT core's input BRAMs. It converts byte addresses to word addresses and counts accepted writes per channel against a runtime-programmed depth. It raises per-channel done flags, fires a one-cycle core start pulse once every channel is full, then tracks the core until completion. It replaces the fixed three-port, software-driven `*_load_done` scheme with a generalised N-channel version that detects errors.

## Interface
Parameters:
- `NUM_CH`, 3, number of load channels (H data, node info, weight by default)
- `DATA_W`, 32, write-data width per channel; narrower BRAMs use the LSBs
- `ADDR_W`, 20, byte-address width on the slave side
- `ADDR_SHIFT`, 2, log2 of bytes per word; word address = `addr[ADDR_W-1:ADDR_SHIFT]`
- `CNT_W`, 18, width of the per-channel depth and counter

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `load_start`  in  1  one-cycle pulse: clears counters and flags, latches `cfg_depth`, enters LOAD
- `cfg_depth`  in  NUM_CH*CNT_W  expected word count per channel, channel k at `[k*CNT_W +: CNT_W]`
- `s_din`  in  NUM_CH*DATA_W  slave write data
- `s_ena`, `s_wea`  in  NUM_CH  slave enable and write enable
- `s_addra`  in  NUM_CH*ADDR_W  slave byte address
- `m_din`  out  NUM_CH*DATA_W  registered write data to the BRAM
- `m_ena`, `m_wea`  out  NUM_CH  registered and gated enables
- `m_addra`  out  NUM_CH*(ADDR_W-ADDR_SHIFT)  registered word address
- `ch_done`  out  NUM_CH  channel k has received `cfg_depth[k]` accepted writes
- `gat_start`  out  1  one-cycle start pulse to the core
- `gat_ready`  in  1  core idle/finished indicator
- `layer_done`  out  1  one-cycle pulse when the core completes
- `busy`  out  1  state is not IDLE
- `err_misalign`  out  NUM_CH  sticky: write with nonzero low `ADDR_SHIFT` bits
- `err_range`  out  NUM_CH  sticky: word address ≥ latched depth
- `err_locked`  out  NUM_CH  sticky: write attempted outside LOAD

## Operation
- FSM states are IDLE, LOAD, START and RUN. The reset state is IDLE.
- IDLE → LOAD on `load_start`. In LOAD, a further `load_start` restarts LOAD: counters, `ch_done` and error flags are cleared and depths are re-latched.
- A write is "accepted" when `s_ena & s_wea`, the state is LOAD, the address is aligned and the word address is below the latched depth. Only accepted writes reach `m_*` (`m_ena`/`m_wea` = 1) and increment that channel's counter.
- Rejected writes are dropped: `m_ena`=0 and the matching sticky error is set. Reads (`s_ena & ~s_wea`) pass through in every state, with `m_wea`=0.
- Counting is by write count, not address coverage. A duplicate address counts twice.
- `ch_done[k]` = (counter[k] == depth[k]). A depth of 0 gives done immediately. The counter saturates at depth, and any further writes set `err_range`.
- LOAD → START when all `ch_done` bits are 1. `gat_start` is high for exactly the START cycle. START → RUN unconditionally.
- In RUN, a rising edge of `gat_ready` (sampled 0 in the previous cycle, 1 now) pulses `layer_done` and moves the FSM to IDLE. Counters are not cleared on this transition.
- `load_start` in START or RUN is ignored.
- Sticky errors clear only on `load_start` or reset.

## Timing
- Reset values: all `m_*`, `ch_done`, `gat_start`, `layer_done`, `busy` and all `err_*` outputs are 0. The counters are 0.
- Write path latency is 1 cycle: an `s_*` input in cycle N appears on `m_*` in cycle N+1.
- The counter updates at the end of cycle N. `ch_done` is high from cycle N+1 (it is a compare on the counter register).
- The last channel's done flag rises in N+1. The FSM enters START at the edge ending N+1, so `gat_start` is high in N+2 only.
- The `gat_ready` edge is detected in cycle M. `layer_done` is high in M+1, and `busy` falls in M+1.
- `load_start` in the same cycle as a write: the restart wins and that write is dropped without setting an error.
- When `rst_n` is asserted mid-operation, all outputs are forced to their reset values immediately (asynchronous). No partial-load state survives.

## Structure
- Shared package `gat_pkg`:
  - FSM state enum `load_state_t` (2 bits)
  - helper `word_addr()`
  - default `ADDR_SHIFT`
- Sub-module `gat_load_ch`, instantiated NUM_CH times in a generate loop. Each instance holds:
  - the input register stage
  - the accept logic
  - the counter and depth latch
  - the three sticky error flags
  - the `ch_done` compare
- The top level holds the FSM, the `gat_ready` edge detector and the AND-reduction of `ch_done`.

## Test plan
- Nominal load: depths {4,2,3}; write byte addresses 0,4,8,12 / 0,4 / 0,4,8 → `m_addra` 0..3 / 0..1 / 0..2 one cycle later; `ch_done`=3'b111; `gat_start` one cycle later for exactly one cycle.
- Misalign and range: write address 0x6 on ch0 → `err_misalign[0]`=1, `m_ena[0]`=0, counter unchanged. Write address 0x40 with depth 4 → `err_range[0]`=1.
- Locked: write in IDLE → dropped, `err_locked`=1. Read in IDLE → `m_ena`=1, `m_wea`=0.
- Completion: hold `gat_ready`=1 through START, drive it 0 then 1 in RUN → `layer_done` pulses once; `busy`=0 the cycle after the edge.
- Zero depth and restart: depths {0,0,1} with one ch2 write → `gat_start` two cycles after the write. Issue `load_start` mid-LOAD after 2 of 4 writes → counters reset to 0, `ch_done`=0.
- Async reset: assert `rst_n`=0 in RUN → `busy`, `ch_done` and `gat_start` go to 0 without waiting for a clock edge.
